// File: rtl/snake_head_mover.sv
// Snake head mover: tick divider, 2-deep turn queue, heading and head position with wall detection.
// Define SNAKE_WRAP_EN to wrap the head around grid edges instead of stopping on a wall.
module snake_head_mover #(
    parameter int unsigned GRID_W   = 32,
    parameter int unsigned GRID_H   = 24,
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned X_W      = 5,
    parameter int unsigned Y_W      = 5
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic [1:0]     direction,
    input  logic           dir_valid,
    input  logic           enable,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     cur_dir,
    output logic           step,
    output logic           wall_hit,
    output logic           queue_full
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       fifo0, fifo1;
    logic [1:0]       fifo_cnt;

    logic             tick_c, pop_c, push_c, blocked_c, move_c;
    logic [1:0]       ref_dir_c, heading_c;
    logic [1:0]       fifo0_n_c, fifo1_n_c, fifo_cnt_n_c;
    logic [X_W-1:0]   nx_c;
    logic [Y_W-1:0]   ny_c;

    // Tick qualification, turn filtering and FIFO next state
    always_comb begin
        tick_c       = enable && (tick_cnt == CNT_W'(TICK_DIV - 1)) && !wall_hit;
        pop_c        = tick_c && (fifo_cnt != 2'd0);
        ref_dir_c    = (fifo_cnt == 2'd2) ? fifo1 : (fifo_cnt == 2'd1) ? fifo0 : cur_dir;
        push_c       = dir_valid && (direction != ref_dir_c) && (direction != ~ref_dir_c)
                       && ((fifo_cnt != 2'd2) || pop_c);
        heading_c    = pop_c ? fifo0 : cur_dir;
        fifo0_n_c    = fifo0;
        fifo1_n_c    = fifo1;
        fifo_cnt_n_c = fifo_cnt;
        if (pop_c) begin
            fifo0_n_c    = fifo1;
            fifo_cnt_n_c = fifo_cnt - 2'd1;
        end
        if (push_c) begin
            if (fifo_cnt_n_c == 2'd0) fifo0_n_c = direction;
            else                      fifo1_n_c = direction;
            fifo_cnt_n_c = fifo_cnt_n_c + 2'd1;
        end
    end

    // Candidate next head position; edge crossings yield the wrapped coordinate
    always_comb begin
        nx_c      = head_x;
        ny_c      = head_y;
        blocked_c = 1'b0;
        case (heading_c)
            DIR_UP: begin
                blocked_c = (head_y == '0);
                ny_c      = blocked_c ? Y_W'(GRID_H - 1) : head_y - Y_W'(1);
            end
            DIR_DOWN: begin
                blocked_c = (head_y == Y_W'(GRID_H - 1));
                ny_c      = blocked_c ? '0 : head_y + Y_W'(1);
            end
            DIR_LEFT: begin
                blocked_c = (head_x == '0);
                nx_c      = blocked_c ? X_W'(GRID_W - 1) : head_x - X_W'(1);
            end
            DIR_RIGHT: begin
                blocked_c = (head_x == X_W'(GRID_W - 1));
                nx_c      = blocked_c ? '0 : head_x + X_W'(1);
            end
            default: blocked_c = 1'b0;
        endcase
        move_c = WRAP_EN || !blocked_c;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            fifo0      <= DIR_UP;
            fifo1      <= DIR_UP;
            fifo_cnt   <= 2'd0;
            queue_full <= 1'b0;
            head_x     <= X_W'(GRID_W / 2);
            head_y     <= Y_W'(GRID_H / 2);
            cur_dir    <= DIR_RIGHT;
            step       <= 1'b0;
            wall_hit   <= 1'b0;
        end else begin
            if (!enable || (tick_cnt == CNT_W'(TICK_DIV - 1))) tick_cnt <= '0;
            else                                                  tick_cnt <= tick_cnt + CNT_W'(1);
            fifo0      <= fifo0_n_c;
            fifo1      <= fifo1_n_c;
            fifo_cnt   <= fifo_cnt_n_c;
            queue_full <= (fifo_cnt_n_c == 2'd2);
            step       <= 1'b0;
            if (tick_c) begin
                cur_dir <= heading_c;
                if (move_c) begin
                    head_x <= nx_c;
                    head_y <= ny_c;
                    step   <= 1'b1;
                end else begin
                    wall_hit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_head_mover.sv
// Scoreboard bench for snake_head_mover: randomized turns/enable against a queue-based reference model.
module tb_snake_head_mover;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int TD = 4;

    logic       CLOCK_50;
    logic       reset;
    logic [1:0] direction;
    logic       dir_valid;
    logic       enable;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [1:0] cur_dir;
    logic       step;
    logic       wall_hit;
    logic       queue_full;

    snake_head_mover #(
        .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD), .X_W(5), .Y_W(5)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .direction (direction),
        .dir_valid (dir_valid),
        .enable    (enable),
        .head_x    (head_x),
        .head_y    (head_y),
        .cur_dir   (cur_dir),
        .step      (step),
        .wall_hit  (wall_hit),
        .queue_full(queue_full)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int dir;
        int stp;
        int wall;
    } ev_t;

    typedef struct {
        int full;
        int wall;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_x, m_y, m_dir, m_cnt, m_wall;
    int m_q[$];

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_x = GW / 2;
        m_y = GH / 2;
        m_dir = 2;
        m_cnt = 0;
        m_wall = 0;
        m_q.delete();
        evq.delete();
        stq.delete();
    endfunction

    // Apply one cycle of stimulus at a falling edge and advance the model by one rising edge
    task automatic drive(input bit dv, input int d, input bit en);
        bit  tick, acc;
        int  refd, nx, ny;
        ev_t e;
        st_t s;
        dir_valid = dv;
        direction = 2'(d);
        enable    = en;
        tick = en && (m_cnt == TD - 1) && (m_wall == 0);
        refd = (m_q.size() != 0) ? m_q[m_q.size() - 1] : m_dir;
        acc  = dv && (d != refd) && (d != 3 - refd)
               && (m_q.size() < 2 || (tick && m_q.size() != 0));
        if (tick) begin
            if (m_q.size() != 0) m_dir = m_q.pop_front();
            nx = m_x;
            ny = m_y;
            case (m_dir)
                0: ny = ny - 1;
                1: nx = nx - 1;
                2: nx = nx + 1;
                default: ny = ny + 1;
            endcase
`ifdef SNAKE_WRAP_EN
            m_x = (nx + GW) % GW;
            m_y = (ny + GH) % GH;
            e = '{x: m_x, y: m_y, dir: m_dir, stp: 1, wall: 0};
`else
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                m_wall = 1;
                e = '{x: m_x, y: m_y, dir: m_dir, stp: 0, wall: 1};
            end else begin
                m_x = nx;
                m_y = ny;
                e = '{x: m_x, y: m_y, dir: m_dir, stp: 1, wall: 0};
            end
`endif
            evq.push_back(e);
        end
        if (acc) m_q.push_back(d);
        m_cnt = en ? (m_cnt + 1) % TD : 0;
        s = '{full: (m_q.size() == 2) ? 1 : 0, wall: m_wall};
        stq.push_back(s);
        @(negedge CLOCK_50);
    endtask

    // Asynchronous reset raised mid-cycle; outputs must settle immediately
    task automatic do_reset();
        dir_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_head_x", int'(head_x), m_x);
        check("rst_head_y", int'(head_y), m_y);
        check("rst_cur_dir", int'(cur_dir), m_dir);
        check("rst_step", int'(step), 0);
        check("rst_wall_hit", int'(wall_hit), 0);
        check("rst_queue_full", int'(queue_full), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    // Monitor: compares status every cycle and pops a move record when the DUT reports a tick result
    initial begin
        ev_t e;
        st_t s;
        bit  wall_prev;
        bit  dut_ev;
        wall_prev = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (stq.size() != 0) begin
                s = stq.pop_front();
                check("queue_full", int'(queue_full), s.full);
                check("wall_hit", int'(wall_hit), s.wall);
            end
            dut_ev = step || (wall_hit && !wall_prev);
            if (evq.size() != 0) begin
                e = evq.pop_front();
                check("tick_head_x", int'(head_x), e.x);
                check("tick_head_y", int'(head_y), e.y);
                check("tick_cur_dir", int'(cur_dir), e.dir);
                check("tick_step", int'(step), e.stp);
                check("tick_wall", int'(wall_hit), e.wall);
            end else if (dut_ev) begin
                check("unexpected_tick_event", 1, 0);
            end
            wall_prev = wall_hit;
        end
    end

    initial begin
        reset     = 1'b1;
        dir_valid = 1'b0;
        direction = 2'b00;
        enable    = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        do_reset();

        // free run heading right
        repeat (9) drive(0, 0, 1);

        // two turns queued, third dropped while full, fourth accepted on tick
        do_reset();
        drive(1, 3, 1);
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        repeat (14) drive(0, 0, 1);

        // reverse and same-direction requests are dropped
        do_reset();
        drive(1, 1, 1);
        drive(1, 2, 1);
        repeat (6) drive(0, 0, 1);

        // run into the right wall (or wrap)
        do_reset();
        repeat (TD * 18) drive(0, 0, 1);
        drive(1, 3, 1);
        drive(1, 1, 1);
        repeat (6) drive(0, 0, 1);

        // reset with two turns pending
        do_reset();
        drive(1, 0, 1);
        drive(1, 1, 1);
        do_reset();

        // randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 400; c++)
                drive(($urandom % 3) == 0, int'($urandom % 4), ($urandom % 16) != 0);
            do_reset();
        end

        @(posedge CLOCK_50);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_head_mover.md
# snake_head_mover

Consumer side of the direction interface: accepts direction codes from the user-input block, buffers up to two pending turns, and advances the snake head one grid cell per move tick. It owns the game-speed tick divider, the current heading, the head coordinates and wall-collision detection. Downstream body/render logic consumes `head_x`, `head_y` and the `step` strobe.

## Interface
- `GRID_W`, 32, grid width in cells (≥2)
- `GRID_H`, 24, grid height in cells (≥2)
- `TICK_DIV`, 12500000, CLOCK_50 cycles per move tick (≥2; default = 4 moves/s)
- `X_W`, 5, width of `head_x` (must hold GRID_W-1)
- `Y_W`, 5, width of `head_y` (must hold GRID_H-1)

- `CLOCK_50`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `direction`  in  2  direction code: 00 up, 01 left, 10 right, 11 down
- `dir_valid`  in  1  one-cycle strobe; `direction` is sampled this cycle
- `enable`  in  1  game running; low freezes tick divider and movement
- `head_x`  out  X_W  head column, 0 = left edge
- `head_y`  out  Y_W  head row, 0 = top edge
- `cur_dir`  out  2  heading applied on the most recent tick
- `step`  out  1  one-cycle pulse: head moved this tick
- `wall_hit`  out  1  sticky collision flag
- `queue_full`  out  1  two turns pending

## Operation
- Reverse of a code is its bitwise complement (up↔down, left↔right).
- Turn queue: 2-entry FIFO. Reference direction = FIFO tail if non-empty, else `cur_dir`.
- On `dir_valid`: drop if `direction` equals the reference or ~reference; drop if full and no pop this cycle; otherwise push.
- Move tick (counter at TICK_DIV-1, `enable` high, `wall_hit` low): pop FIFO head into `cur_dir` if non-empty, then move one cell in the resulting heading: up y-1, down y+1, left x-1, right x+1.
- Wall: if the move would leave 0..GRID_W-1 / 0..GRID_H-1, position holds, `wall_hit` sets, `step` stays low. Pop still occurs.
- Once `wall_hit` is set: no further ticks act, pushes are still accepted/filtered; only `reset` clears it.
- Simultaneous push and pop: both occur; reference is evaluated before the pop; full check passes because an entry frees.
- `enable` low: tick counter cleared to 0 and held; FIFO still accepts pushes.

## Timing
- Reset values: `head_x` = GRID_W/2, `head_y` = GRID_H/2, `cur_dir` = 2'b10, FIFO empty, `queue_full` 0, counter 0, `step` 0, `wall_hit` 0.
- Tick period exactly TICK_DIV cycles with `enable` held high; first tick TICK_DIV cycles after `enable` rises.
- `head_x`, `head_y`, `cur_dir`, `wall_hit` update on the tick edge; `step` is high for the one cycle immediately after, coincident with new coordinates.
- `dir_valid` affects heading no earlier than the next tick; a push on the tick cycle itself is eligible for pop only on the following tick, except when the FIFO was empty it is not bypassed.
- `queue_full` registered, reflects count after the current edge.
- `reset` asserted mid-tick or mid-push: all state returns to reset values immediately, no partial update.

## Configuration
- `SNAKE_WRAP_EN` defined: moves off an edge wrap to the opposite edge (x: 0↔GRID_W-1, y: 0↔GRID_H-1), `step` pulses, `wall_hit` tied 0.
- Not defined: wall-collision behaviour as above.

## Test plan
- Reset, GRID 32×24, TICK_DIV=4, `enable`=1, no input → `step` every 4 cycles, head (16,12)→(17,12)→(18,12), `cur_dir`=10.
- From heading right, push 11 (down) then 01 (left) before one tick → tick1 `cur_dir`=11, head y+1; tick2 `cur_dir`=01, x-1; `queue_full` high after second push.
- Heading right, push 01 (reverse) and 10 (same) → both dropped, FIFO stays empty, heading unchanged.
- FIFO full, third `dir_valid` without tick → dropped; third push on a tick cycle → accepted, `queue_full` remains 1.
- Heading right from x=30, without `SNAKE_WRAP_EN` → tick to 31 with `step`, next tick `wall_hit`=1, x stays 31, no `step`; with macro → x=0, `step`=1, `wall_hit`=0.
- Assert `reset` mid-run with 2 turns queued → outputs return to (16,12), 10, FIFO empty, `wall_hit` 0 within the same cycle.
